// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: decode-side controls, instruction memory and IF/ID signals of the fetch stage
interface if_fetch_stage_if #(
    parameter int CNT_WIDTH = 16
);
    logic                 stall;
    logic                 branch_taken;
    logic [31:0]          branch_pc4;
    logic [31:0]          branch_offset;
    logic                 jump;
    logic [31:0]          jump_pc4;
    logic [25:0]          jump_index;
    logic [31:0]          instr_in;
    logic [31:0]          pc;
    logic [31:0]          ifid_instr;
    logic [31:0]          ifid_pc4;
    logic                 ifid_valid;
    logic [CNT_WIDTH-1:0] redirect_cnt;

    // Decode and the instruction memory drive the fetch stage
    modport master (
        output stall, branch_taken, branch_pc4, branch_offset,
               jump, jump_pc4, jump_index, instr_in,
        input  pc, ifid_instr, ifid_pc4, ifid_valid, redirect_cnt
    );

    // The fetch stage itself
    modport slave (
        input  stall, branch_taken, branch_pc4, branch_offset,
               jump, jump_pc4, jump_index, instr_in,
        output pc, ifid_instr, ifid_pc4, ifid_valid, redirect_cnt
    );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC ownership, next-PC selection, IF/ID register and saturating redirect counter
module if_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_WIDTH = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    if_fetch_stage_if.slave   bus
);
    logic [31:0]          pc_q, pc_d;
    logic [31:0]          ifid_instr_q, ifid_instr_d;
    logic [31:0]          ifid_pc4_q, ifid_pc4_d;
    logic                 ifid_valid_q, ifid_valid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          pc4, btarget, jtarget, target;
    logic                 redirect;

    assign pc4      = pc_q + 32'd4;
    assign btarget  = bus.branch_pc4 + (bus.branch_offset << 2);
    assign jtarget  = {bus.jump_pc4[31:28], bus.jump_index, 2'b00};
    assign redirect = bus.jump | bus.branch_taken;

    // Next PC: jump beats branch, any redirect beats stall; low bits kept word aligned
    always_comb begin
        target = bus.jump ? jtarget : bus.branch_taken ? btarget : bus.stall ? pc_q : pc4;
        pc_d   = {target[31:2], 2'b00};
    end

    // IF/ID next state: a redirect squashes the current fetch, a stall holds the register
    always_comb begin
        ifid_instr_d = redirect ? 32'h0 : bus.stall ? ifid_instr_q : bus.instr_in;
        ifid_pc4_d   = redirect ? 32'h0 : bus.stall ? ifid_pc4_q   : pc4;
        ifid_valid_d = redirect ? 1'b0  : bus.stall ? ifid_valid_q : 1'b1;
        cnt_d        = (redirect && !(&cnt_q)) ? cnt_q + CNT_WIDTH'(1) : cnt_q;
    end

    // State registers with immediate asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q         <= {RESET_PC[31:2], 2'b00};
            ifid_instr_q <= 32'h0;
            ifid_pc4_q   <= 32'h0;
            ifid_valid_q <= 1'b0;
            cnt_q        <= '0;
        end else begin
            pc_q         <= pc_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_valid_q <= ifid_valid_d;
            cnt_q        <= cnt_d;
        end
    end

    assign bus.pc           = pc_q;
    assign bus.ifid_instr   = ifid_instr_q;
    assign bus.ifid_pc4     = ifid_pc4_q;
    assign bus.ifid_valid   = ifid_valid_q;
    assign bus.redirect_cnt = cnt_q;
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: scoreboard bench with a spec-level fetch model, plus reset-vector wrap and saturation checks
module tb_if_fetch_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst2_n = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    if_fetch_stage_if #(.CNT_WIDTH(16)) b1 ();
    if_fetch_stage_if #(.CNT_WIDTH(2))  b2 ();

    if_fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_WIDTH(16)) dut (.clk(clk), .rst_n(rst_n), .bus(b1));
    if_fetch_stage #(.RESET_PC(32'hFFFF_FFFF), .CNT_WIDTH(2))  dut2 (.clk(clk), .rst_n(rst2_n), .bus(b2));

    // Stub memories: each word holds its own word index
    assign b1.instr_in = b1.pc >> 2;
    assign b2.instr_in = b2.pc >> 2;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] pc4;
        logic        valid;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        got;
    logic [31:0] m_pc, m_instr, m_pc4;
    logic        m_valid;
    logic [15:0] m_cnt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic mreset();
        m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_cnt = 16'h0;
    endtask

    // One fetch cycle: drive decode controls at the negedge, advance the model, let the edge happen
    task automatic step(input logic j, input logic [31:0] jpc4, input logic [25:0] jidx,
                        input logic br, input logic [31:0] bpc4, input logic [31:0] boff,
                        input logic st);
        exp_t e;
        @(negedge clk);
        b1.jump = j; b1.jump_pc4 = jpc4; b1.jump_index = jidx;
        b1.branch_taken = br; b1.branch_pc4 = bpc4; b1.branch_offset = boff; b1.stall = st;
        if (j || br) begin
            m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        end else if (!st) begin
            m_instr = m_pc / 4; m_pc4 = m_pc + 4; m_valid = 1'b1;
        end
        if (j)       m_pc = {jpc4[31:28], jidx, 2'b00};
        else if (br) m_pc = bpc4 + boff * 4;
        else if (!st) m_pc = m_pc + 4;
        e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.cnt = m_cnt;
        sb.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 26'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    endtask

    // Monitor: the stage presents a new IF/ID state every edge; compare against the oldest expectation
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                got = sb.pop_front();
                chk("sb_pc",    b1.pc,                 got.pc);
                chk("sb_instr", b1.ifid_instr,         got.instr);
                chk("sb_pc4",   b1.ifid_pc4,           got.pc4);
                chk("sb_valid", 32'(b1.ifid_valid),    32'(got.valid));
                chk("sb_cnt",   32'(b1.redirect_cnt),  32'(got.cnt));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, o;
        {b1.jump, b1.branch_taken, b1.stall} = 3'b000;
        b1.jump_pc4 = 0; b1.jump_index = 0; b1.branch_pc4 = 0; b1.branch_offset = 0;
        {b2.jump, b2.branch_taken, b2.stall} = 3'b000;
        b2.jump_pc4 = 0; b2.jump_index = 0; b2.branch_pc4 = 0; b2.branch_offset = 0;
        mreset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_pc",    b1.pc,                 32'h0);
        chk("rst_instr", b1.ifid_instr,         32'h0);
        chk("rst_pc4",   b1.ifid_pc4,           32'h0);
        chk("rst_valid", 32'(b1.ifid_valid),    32'h0);
        chk("rst_cnt",   32'(b1.redirect_cnt),  32'h0);
        rst_n = 1'b1;

        // Sequential fetch
        idle();
        chk("seq1_pc", b1.pc, 32'h4);
        chk("seq1_pc4", b1.ifid_pc4, 32'h4);
        chk("seq1_valid", 32'(b1.ifid_valid), 32'h1);
        idle();
        idle();
        chk("seq3_pc", b1.pc, 32'hC);
        chk("seq3_instr", b1.ifid_instr, 32'h2);
        chk("seq3_pc4", b1.ifid_pc4, 32'hC);

        // Forward branch
        step(1'b0, 32'h0, 26'h0, 1'b1, 32'h24, 32'h9, 1'b0);
        chk("br_pc", b1.pc, 32'h48);
        chk("br_valid", 32'(b1.ifid_valid), 32'h0);
        chk("br_cnt", 32'(b1.redirect_cnt), 32'h1);
        idle();
        chk("br_next_pc4", b1.ifid_pc4, 32'h4C);
        chk("br_next_valid", 32'(b1.ifid_valid), 32'h1);

        // Backward branch
        step(1'b0, 32'h0, 26'h0, 1'b1, 32'h40, 32'hFFFF_FFFC, 1'b0);
        chk("nbr_pc", b1.pc, 32'h30);

        // Jump, branch and stall together: jump wins, counted once
        step(1'b1, 32'h48, 26'h0E, 1'b1, 32'h100, 32'h4, 1'b1);
        chk("jmp_pc", b1.pc, 32'h38);
        chk("jmp_valid", 32'(b1.ifid_valid), 32'h0);
        chk("jmp_cnt", 32'(b1.redirect_cnt), 32'h3);

        // Stall at 0x10
        step(1'b0, 32'h0, 26'h0, 1'b1, 32'hC, 32'h0, 1'b0);
        idle();
        step(1'b0, 32'h0, 26'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 26'h0, 1'b0, 32'h0, 32'h0, 1'b1);
        chk("stall_pc", b1.pc, 32'h10);
        chk("stall_instr", b1.ifid_instr, 32'h3);
        chk("stall_pc4", b1.ifid_pc4, 32'h10);
        idle();
        chk("unstall_pc", b1.pc, 32'h14);
        chk("unstall_instr", b1.ifid_instr, 32'h4);

        // Randomized traffic
        repeat (400) begin
            r = $urandom;
            o = $urandom;
            step(r[2:0] == 3'd0, $urandom, 26'($urandom), r[5:3] < 3'd2,
                 $urandom & 32'hFFFF_FFFC, {{16{o[15]}}, o[15:0]}, r[7:6] == 2'd0);
        end

        // Asynchronous reset between edges
        rst_n = 1'b0;
        #1;
        chk("arst_pc", b1.pc, 32'h0);
        chk("arst_valid", 32'(b1.ifid_valid), 32'h0);
        chk("arst_pc4", b1.ifid_pc4, 32'h0);
        chk("arst_cnt", 32'(b1.redirect_cnt), 32'h0);
        mreset();
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        idle();
        chk("post_rst_pc", b1.pc, 32'h4);
        idle();
        chk("sb_drained", 32'(sb.size()), 32'h0);

        // Reset vector at the top of memory: low bits forced, wraps to 0
        chk("wrap_rst_pc", b2.pc, 32'hFFFF_FFFC);
        rst2_n = 1'b1;
        @(posedge clk);
        #2;
        chk("wrap_pc", b2.pc, 32'h0);
        chk("wrap_pc4", b2.ifid_pc4, 32'h0);
        chk("wrap_instr", b2.ifid_instr, 32'h3FFF_FFFF);
        chk("wrap_valid", 32'(b2.ifid_valid), 32'h1);

        // Counter saturation on a narrow counter
        @(negedge clk);
        b2.jump = 1'b1; b2.jump_pc4 = 32'h0; b2.jump_index = 26'h10;
        repeat (5) @(posedge clk);
        #2;
        chk("sat_cnt", 32'(b2.redirect_cnt), 32'h3);
        chk("sat_pc", b2.pc, 32'h40);
        rst2_n = 1'b0;
        #1;
        chk("wrap_arst_cnt", 32'(b2.redirect_cnt), 32'h0);
        chk("wrap_arst_pc", b2.pc, 32'hFFFF_FFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
